// File: rtl/sha1_hash_engine.sv
// SHA-1 engine: fetches a message over dpsram port A, pads it in hardware, runs 1/2/4 rounds per clock.
// Define SHA1_HASH_WRITEBACK_EN to add hash_addr and write the byte-swapped digest back over port A.
module sha1_hash_engine #(
    parameter int unsigned ROUNDS_PER_CYCLE = 1,
    parameter int unsigned ADDR_W           = 16
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              start_hash,
    input  logic [31:0]       message_addr,
    input  logic [31:0]       message_size,
`ifdef SHA1_HASH_WRITEBACK_EN
    input  logic [31:0]       hash_addr,
`endif
    output logic [159:0]      hash,
    output logic              done,
    output logic              busy,
    output logic              port_A_clk,
    output logic [ADDR_W-1:0] port_A_addr,
    input  logic [31:0]       port_A_data_out,
    output logic [31:0]       port_A_data_in,
    output logic              port_A_we
);

    if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4)) begin : g_bad_rounds
        $error("sha1_hash_engine: ROUNDS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [2:0] {
        IDLE, LOAD, ROUNDS, UPDATE,
`ifdef SHA1_HASH_WRITEBACK_EN
        WRITE,
`endif
        DONE
    } state_t;

    localparam logic [31:0] IV0 = 32'h6745_2301;
    localparam logic [31:0] IV1 = 32'hefcd_ab89;
    localparam logic [31:0] IV2 = 32'h98ba_dcfe;
    localparam logic [31:0] IV3 = 32'h1032_5476;
    localparam logic [31:0] IV4 = 32'hc3d2_e1f0;
    localparam logic [6:0]  R7  = 7'(ROUNDS_PER_CYCLE);

    function automatic logic [31:0] bswap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    // Padding is applied as each word is captured, so the buffer only ever holds final schedule words.
    function automatic logic [31:0] pad_word(input logic [32:0] off, input logic [31:0] size,
                                             input logic [31:0] data, input logic last,
                                             input logic [3:0] idx);
        logic [32:0] sz;
        logic [31:0] bs;
        sz = {1'b0, size};
        bs = bswap(data);
        if (last && idx == 4'd14)      return {29'd0, size[31:29]};
        else if (last && idx == 4'd15) return {size[28:0], 3'd0};
        else if (off + 33'd4 <= sz)    return bs;
        else if (off < sz) begin
            case (size[1:0])
                2'd1:    return {bs[31:24], 8'h80, 16'h0000};
                2'd2:    return {bs[31:16], 8'h80, 8'h00};
                default: return {bs[31:8], 8'h80};
            endcase
        end
        else if (off == sz)            return 32'h8000_0000;
        else                           return '0;
    endfunction

    function automatic logic [31:0] f_round(input logic [6:0] t, input logic [31:0] b,
                                            input logic [31:0] c, input logic [31:0] d);
        if (t < 7'd20)                     return (b & c) | (~b & d);
        else if (t < 7'd40 || t >= 7'd60)  return b ^ c ^ d;
        else                               return (b & c) | (b & d) | (c & d);
    endfunction

    function automatic logic [31:0] k_const(input logic [6:0] t);
        if (t < 7'd20)      return 32'h5a82_7999;
        else if (t < 7'd40) return 32'h6ed9_eba1;
        else if (t < 7'd60) return 32'h8f1b_bcdc;
        else                return 32'hca62_c1d6;
    endfunction

    state_t      state;
    logic [31:0] msg_addr, msg_size;
    logic [26:0] blk, last_blk;
    logic [4:0]  cnt;
    logic [6:0]  t;
    logic [31:0] w  [16];
    logic [31:0] wn [16];
    logic [31:0] a, b, c, d, e;
    logic [31:0] na, nb, nc, nd, ne;
    logic [31:0] h0, h1, h2, h3, h4;
    logic [32:0] size_sum, cap_off, iss_off, nxt_off;
    logic [3:0]  cap_idx, iss_idx;
    logic        is_last;

    assign port_A_clk = clk;
    assign hash       = {h0, h1, h2, h3, h4};
    assign size_sum   = {1'b0, msg_size} + 33'd8;
    assign last_blk   = size_sum[32:6];
    assign is_last    = (blk == last_blk);
    assign cap_idx    = 4'(cnt - 5'd1);
    assign iss_idx    = 4'(cnt + 5'd1);
    assign cap_off    = {blk, 6'd0} + {27'd0, cap_idx, 2'd0};
    assign iss_off    = {blk, 6'd0} + {27'd0, iss_idx, 2'd0};
    assign nxt_off    = {blk + 27'd1, 6'd0};

    // Rounds within one clock are chained; schedule words produced earlier in the same clock feed later ones.
    always_comb begin : rounds_comb
        logic [6:0]  tj;
        logic [31:0] wt, tmp;
        wn = w;
        na = a; nb = b; nc = c; nd = d; ne = e;
        tj = '0; wt = '0; tmp = '0;
        for (int unsigned j = 0; j < ROUNDS_PER_CYCLE; j++) begin
            tj = t + 7'(j);
            if (tj >= 7'd16) begin
                wt = wn[4'(tj - 7'd3)] ^ wn[4'(tj - 7'd8)] ^ wn[4'(tj - 7'd14)] ^ wn[tj[3:0]];
                wt = {wt[30:0], wt[31]};
                wn[tj[3:0]] = wt;
            end else begin
                wt = wn[tj[3:0]];
            end
            tmp = {na[26:0], na[31:27]} + f_round(tj, nb, nc, nd) + ne + k_const(tj) + wt;
            ne = nd; nd = nc; nc = {nb[1:0], nb[31:2]}; nb = na; na = tmp;
        end
    end

`ifdef SHA1_HASH_WRITEBACK_EN
    logic [31:0] hash_addr_q, data_in_q;
    logic [2:0]  wcnt;
    logic        we_q;
    assign port_A_we      = we_q;
    assign port_A_data_in = data_in_q;
`else
    assign port_A_we      = 1'b0;
    assign port_A_data_in = '0;
`endif

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state <= IDLE; done <= 1'b0; busy <= 1'b0; port_A_addr <= '0;
            msg_addr <= '0; msg_size <= '0; blk <= '0; cnt <= '0; t <= '0;
            a <= '0; b <= '0; c <= '0; d <= '0; e <= '0;
            h0 <= '0; h1 <= '0; h2 <= '0; h3 <= '0; h4 <= '0;
            for (int unsigned i = 0; i < 16; i++) w[i] <= '0;
`ifdef SHA1_HASH_WRITEBACK_EN
            hash_addr_q <= '0; data_in_q <= '0; wcnt <= '0; we_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: if (start_hash) begin
                    msg_addr <= message_addr; msg_size <= message_size;
`ifdef SHA1_HASH_WRITEBACK_EN
                    hash_addr_q <= hash_addr;
`endif
                    a <= IV0; b <= IV1; c <= IV2; d <= IV3; e <= IV4;
                    h0 <= IV0; h1 <= IV1; h2 <= IV2; h3 <= IV3; h4 <= IV4;
                    done <= 1'b0; busy <= 1'b1; blk <= '0; cnt <= '0;
                    if (message_size != 32'd0) port_A_addr <= ADDR_W'(message_addr);
                    state <= LOAD;
                end
                LOAD: begin
                    if (cnt != 5'd0) w[cap_idx] <= pad_word(cap_off, msg_size, port_A_data_out, is_last, cap_idx);
                    if (cnt < 5'd15 && iss_off < {1'b0, msg_size})
                        port_A_addr <= ADDR_W'(msg_addr + iss_off[31:0]);
                    if (cnt == 5'd16) begin
                        t <= '0;
                        state <= ROUNDS;
                    end
                    cnt <= cnt + 5'd1;
                end
                ROUNDS: begin
                    w <= wn;
                    a <= na; b <= nb; c <= nc; d <= nd; e <= ne;
                    t <= t + R7;
                    if (t + R7 == 7'd80) state <= UPDATE;
                end
                UPDATE: begin
                    h0 <= h0 + a; h1 <= h1 + b; h2 <= h2 + c; h3 <= h3 + d; h4 <= h4 + e;
                    a <= h0 + a; b <= h1 + b; c <= h2 + c; d <= h3 + d; e <= h4 + e;
                    if (!is_last) begin
                        blk <= blk + 27'd1; cnt <= '0;
                        if (nxt_off < {1'b0, msg_size}) port_A_addr <= ADDR_W'(msg_addr + nxt_off[31:0]);
                        state <= LOAD;
                    end else begin
`ifdef SHA1_HASH_WRITEBACK_EN
                        wcnt <= '0; we_q <= 1'b1;
                        port_A_addr <= ADDR_W'(hash_addr_q);
                        data_in_q <= bswap(h0 + a);
                        state <= WRITE;
`else
                        done <= 1'b1; busy <= 1'b0;
                        state <= DONE;
`endif
                    end
                end
`ifdef SHA1_HASH_WRITEBACK_EN
                WRITE: begin
                    if (wcnt == 3'd4) begin
                        we_q <= 1'b0; done <= 1'b1; busy <= 1'b0;
                        state <= DONE;
                    end else begin
                        wcnt <= wcnt + 3'd1;
                        port_A_addr <= ADDR_W'(hash_addr_q + {27'd0, 3'(wcnt + 3'd1), 2'd0});
                        case (wcnt)
                            3'd0:    data_in_q <= bswap(h1);
                            3'd1:    data_in_q <= bswap(h2);
                            3'd2:    data_in_q <= bswap(h3);
                            default: data_in_q <= bswap(h4);
                        endcase
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha1_hash_engine.sv
// Bench for sha1_hash_engine: three instances (1, 2 and 4 rounds/clock) share one dpsram image and are
// checked against a plain SHA-1 reference; honours SHA1_HASH_WRITEBACK_EN when defined.
module tb_sha1_hash_engine;

    localparam int unsigned NDUT = 3;
`ifdef SHA1_HASH_WRITEBACK_EN
    localparam int unsigned WB_CYC = 5;
    localparam int unsigned WB_WR  = 5;
    logic [31:0] hash_addr = 32'h0000_0100;
`else
    localparam int unsigned WB_CYC = 0;
    localparam int unsigned WB_WR  = 0;
`endif
    localparam logic [159:0] IV = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        start_hash = 1'b0;
    logic [31:0] message_addr = '0;
    logic [31:0] message_size = '0;

    logic [159:0] hash_v [NDUT];
    logic         done_v [NDUT];
    logic         busy_v [NDUT];
    logic         pclk_v [NDUT];
    logic         we_v   [NDUT];
    logic [15:0]  addr_v [NDUT];
    logic [31:0]  dout_v [NDUT];
    logic [31:0]  din_v  [NDUT];

    logic [7:0]   mem [0:65535];
    int unsigned  wr_total [NDUT] = '{0, 0, 0};
    logic [15:0]  wlog_a [NDUT][8];
    logic [31:0]  wlog_d [NDUT][8];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        sha1_hash_engine #(.ROUNDS_PER_CYCLE(1 << g), .ADDR_W(16)) u_dut (
            .clk(clk), .nreset(nreset), .start_hash(start_hash),
            .message_addr(message_addr), .message_size(message_size),
`ifdef SHA1_HASH_WRITEBACK_EN
            .hash_addr(hash_addr),
`endif
            .hash(hash_v[g]), .done(done_v[g]), .busy(busy_v[g]),
            .port_A_clk(pclk_v[g]), .port_A_addr(addr_v[g]),
            .port_A_data_out(dout_v[g]), .port_A_data_in(din_v[g]), .port_A_we(we_v[g])
        );
    end

    always @(posedge clk) begin
        for (int g = 0; g < NDUT; g++) begin
            dout_v[g] <= {mem[addr_v[g] + 16'd3], mem[addr_v[g] + 16'd2], mem[addr_v[g] + 16'd1], mem[addr_v[g]]};
            if (we_v[g]) begin
                wlog_a[g][wr_total[g] % 8] <= addr_v[g];
                wlog_d[g][wr_total[g] % 8] <= din_v[g];
                wr_total[g] <= wr_total[g] + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rol(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Textbook SHA-1: pad a byte queue, expand 80 schedule words per block.
    function automatic logic [159:0] ref_sha1(input int unsigned base, input int unsigned size);
        logic [7:0]  q[$];
        logic [31:0] w [80];
        logic [31:0] h [5];
        logic [31:0] a, b, c, d, e, f, k, tmp;
        logic [63:0] bits;
        int          p;
        for (int unsigned i = 0; i < size; i++) q.push_back(mem[16'(base + i)]);
        q.push_back(8'h80);
        while (q.size() % 64 != 56) q.push_back(8'h00);
        bits = 64'(size) * 64'd8;
        for (int i = 7; i >= 0; i--) q.push_back(bits[8*i +: 8]);
        h = '{32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476, 32'hc3d2e1f0};
        for (int blk = 0; blk < q.size() / 64; blk++) begin
            for (int t = 0; t < 16; t++) begin
                p = 64 * blk + 4 * t;
                w[t] = {q[p], q[p+1], q[p+2], q[p+3]};
            end
            for (int t = 16; t < 80; t++) w[t] = rol(w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16], 1);
            a = h[0]; b = h[1]; c = h[2]; d = h[3]; e = h[4];
            for (int t = 0; t < 80; t++) begin
                if (t < 20)      begin f = (b & c) | (~b & d);          k = 32'h5a827999; end
                else if (t < 40) begin f = b ^ c ^ d;                   k = 32'h6ed9eba1; end
                else if (t < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8f1bbcdc; end
                else             begin f = b ^ c ^ d;                   k = 32'hca62c1d6; end
                tmp = rol(a, 5) + f + e + k + w[t];
                e = d; d = c; c = rol(b, 30); b = a; a = tmp;
            end
            h[0] += a; h[1] += b; h[2] += c; h[3] += d; h[4] += e;
        end
        return {h[0], h[1], h[2], h[3], h[4]};
    endfunction

    task automatic load_str(input int unsigned base, input string s);
        for (int i = 0; i < s.len(); i++) mem[16'(base + i)] = s[i];
    endtask

    task automatic chk_reset_outputs(input string name);
        for (int g = 0; g < NDUT; g++) begin
            chk($sformatf("%s_r%0d_hash", name, 1 << g), hash_v[g], '0);
            chk($sformatf("%s_r%0d_done", name, 1 << g), 160'(done_v[g]), 160'(0));
            chk($sformatf("%s_r%0d_busy", name, 1 << g), 160'(busy_v[g]), 160'(0));
            chk($sformatf("%s_r%0d_addr", name, 1 << g), 160'(addr_v[g]), 160'(0));
            chk($sformatf("%s_r%0d_we", name, 1 << g), 160'(we_v[g]), 160'(0));
            chk($sformatf("%s_r%0d_din", name, 1 << g), 160'(din_v[g]), 160'(0));
        end
    endtask

    // Starts all instances together, optionally pokes start_hash mid-run, then checks timing and digest.
    task automatic run_hash(input string name, input int unsigned base, input int unsigned size,
                            input logic [159:0] exp, input bit poke_start);
        int unsigned done_cyc [NDUT];
        int unsigned expc [NDUT];
        int unsigned wbase [NDUT];
        int unsigned nblk;
        bit          all_done;
        nblk = (size + 72) / 64;
        for (int g = 0; g < NDUT; g++) begin
            expc[g] = nblk * (18 + 80 / (1 << g)) + WB_CYC;
            done_cyc[g] = 0;
            wbase[g] = wr_total[g];
        end
        message_addr = base;
        message_size = size;
        start_hash = 1'b1;
        @(posedge clk); #1;
        start_hash = 1'b0;
        message_addr = $urandom;
        message_size = $urandom;
        for (int g = 0; g < NDUT; g++) begin
            chk($sformatf("%s_r%0d_acc_busy", name, 1 << g), 160'(busy_v[g]), 160'(1));
            chk($sformatf("%s_r%0d_acc_done", name, 1 << g), 160'(done_v[g]), 160'(0));
            chk($sformatf("%s_r%0d_acc_iv", name, 1 << g), hash_v[g], IV);
        end
        for (int unsigned cyc = 1; cyc <= 2000; cyc++) begin
            start_hash = (poke_start && cyc == 20);
            @(posedge clk); #1;
            all_done = 1'b1;
            for (int g = 0; g < NDUT; g++) begin
                if (done_v[g] && done_cyc[g] == 0) done_cyc[g] = cyc;
                if (done_cyc[g] == 0) all_done = 1'b0;
            end
            if (all_done) break;
        end
        start_hash = 1'b0;
        for (int g = 0; g < NDUT; g++) begin
            chk($sformatf("%s_r%0d_done_cycle", name, 1 << g), 160'(done_cyc[g]), 160'(expc[g]));
            chk($sformatf("%s_r%0d_hash", name, 1 << g), hash_v[g], exp);
        end
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < NDUT; g++) begin
            chk($sformatf("%s_r%0d_hold_hash", name, 1 << g), hash_v[g], exp);
            chk($sformatf("%s_r%0d_hold_done", name, 1 << g), 160'(done_v[g]), 160'(1));
            chk($sformatf("%s_r%0d_hold_busy", name, 1 << g), 160'(busy_v[g]), 160'(0));
            chk($sformatf("%s_r%0d_nwrites", name, 1 << g), 160'(wr_total[g] - wbase[g]), 160'(WB_WR));
`ifdef SHA1_HASH_WRITEBACK_EN
            for (int k = 0; k < 5; k++) begin
                logic [31:0] hw;
                hw = exp[159 - 32*k -: 32];
                chk($sformatf("%s_r%0d_wr%0d_addr", name, 1 << g, k),
                    160'(wlog_a[g][(wbase[g] + k) % 8]), 160'(16'h0100 + 16'(4 * k)));
                chk($sformatf("%s_r%0d_wr%0d_data", name, 1 << g, k),
                    160'(wlog_d[g][(wbase[g] + k) % 8]), 160'({hw[7:0], hw[15:8], hw[23:16], hw[31:24]}));
            end
`endif
        end
    endtask

    initial begin
        int unsigned sizes [10];
        int unsigned base;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        load_str(32'h0300, "abc");
        load_str(32'h0400, "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");

        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        for (int g = 0; g < NDUT; g++)
            chk($sformatf("pclk_r%0d", 1 << g), 160'(pclk_v[g]), 160'(clk));
        nreset = 1'b1;
        @(posedge clk); #1;

        run_hash("empty", 32'h0200, 0, 160'hda39a3ee5e6b4b0d3255bfef95601890afd80709, 1'b0);
        run_hash("abc", 32'h0300, 3, 160'ha9993e364706816aba3e25717850c26c9cd0d89d, 1'b0);
        run_hash("abc56", 32'h0400, 56, 160'h84983e441c3bd26ebaae4aa1f95129e5e54670f1, 1'b0);
        run_hash("poke", 32'h0400, 56, 160'h84983e441c3bd26ebaae4aa1f95129e5e54670f1, 1'b1);
        run_hash("restart", 32'h0300, 3, 160'ha9993e364706816aba3e25717850c26c9cd0d89d, 1'b0);

        message_addr = 32'h0400;
        message_size = 56;
        start_hash = 1'b1;
        @(posedge clk); #1;
        start_hash = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        nreset = 1'b0;
        #1;
        chk_reset_outputs("abort");
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        @(posedge clk); #1;
        run_hash("after_abort", 32'h0300, 3, 160'ha9993e364706816aba3e25717850c26c9cd0d89d, 1'b0);

        sizes = '{55, 56, 63, 64, 119, 120, 0, 0, 0, 0};
        for (int i = 6; i < 10; i++) sizes[i] = $urandom_range(1, 190);
        for (int i = 0; i < 10; i++) begin
            base = 32'h1000 + ($urandom_range(0, 4000) << 2);
            run_hash($sformatf("rand%0d_sz%0d", i, sizes[i]), base, sizes[i], ref_sha1(base, sizes[i]), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sha1_hash_engine.md
# sha1_hash_engine

Parametrised SHA-1 engine, successor to the single-round hash block. It fetches a byte-addressed message from the shared dpsram over port A, applies FIPS 180-4 padding in hardware, and can issue 1, 2 or 4 rounds per cycle. It stores the message schedule in a 16-word circular buffer rather than 80 registers, and uses a clean start/busy/done handshake. It sits beside the other dpsram-attached engines and is driven by the same testbench harness.

## Interface
- ROUNDS_PER_CYCLE, 1, SHA-1 rounds per clock; legal values 1, 2 and 4; any other value is an elaboration error.
- ADDR_W, 16, width of port_A_addr.
- clk  input  1  clock; also drives port_A_clk.
- nreset  input  1  asynchronous, active-low reset.
- start_hash  input  1  request; sampled only in IDLE or DONE.
- message_addr  input  32  byte address of the message; low ADDR_W bits are used; must be 4-byte aligned.
- message_size  input  32  message length in bytes; latched at accept.
- hash  output  160  {H0,H1,H2,H3,H4}.
- done  output  1  result valid.
- busy  output  1  high from accept until done.
- port_A_clk  output  1  equals clk.
- port_A_addr  output  ADDR_W  dpsram address.
- port_A_data_out  input  32  dpsram read data; 1-cycle latency.
- port_A_data_in  output  32  dpsram write data.
- port_A_we  output  1  dpsram write enable.

## Operation
- States: IDLE, LOAD, ROUNDS, UPDATE, (WRITE), DONE.
- Accept:
  - Condition: start_hash=1 in IDLE or DONE.
  - Latches message_addr and message_size.
  - Sets A..E and H0..H4 to 67452301, efcdab89, 98badcfe, 10325476, c3d2e1f0.
  - Clears done, sets busy, and enters LOAD with block index b=0.
- Block count: N = floor((message_size+8)/64)+1.
- LOAD: word i (0..15) has byte offset o = 64b+4i.
  - o+4 ≤ size: W = byte-swap(data_out); message byte 0 is data_out[7:0].
  - o < size < o+4: byte-swapped data, bytes at or beyond size zeroed, and 0x80 placed in the byte at position size%4.
  - o == size: W = 80000000.
  - Other offsets: W = 0.
  - Last block only: W14 = size[31:29], zero-extended; W15 = size<<3. These override the rules above.
  - A word is fetched only when o < size. port_A_addr = message_addr + o. Otherwise the address holds its previous value.
- ROUNDS:
  - R = ROUNDS_PER_CYCLE rounds per cycle, 80/R cycles in total.
  - For t ≥ 16: W[t] = rotl1(W[t-3]^W[t-8]^W[t-14]^W[t-16]), computed in place in the circular buffer.
  - Round functions and constants by t: Ch with 5a827999 for 0-19; Parity with 6ed9eba1 for 20-39; Maj with 8f1bbcdc for 40-59; Parity with ca62c1d6 for 60-79.
- UPDATE:
  - Hi += corresponding working variable, mod 2^32.
  - A..E reload from the new H.
  - If b < N-1: b++ and return to LOAD. Else go to WRITE if compiled in, otherwise DONE.
- DONE: done=1, busy=0, hash held stable until the next accept.
- start_hash while busy is ignored, with no effect on state.
- Reset values: done=0, busy=0, hash=0, port_A_addr=0, port_A_we=0, port_A_data_in=0, state IDLE.
- Reset mid-operation aborts immediately; no dpsram write occurs afterwards.

## Timing
- Accept edge: E0.
- LOAD occupies 17 cycles: addresses go out in cycles 1-16 and data is captured in cycles 2-17.
- ROUNDS occupies 80/R cycles; UPDATE occupies 1 cycle.
- done and busy change on edge E0 + N·(18+80/R), plus 5 when writeback is enabled.
- Restart from DONE: done falls on the accept edge, and hash clears to the IV only at that edge.
- port_A_we is never asserted outside WRITE.

## Configuration
- SHA1_HASH_WRITEBACK_EN defined:
  - Adds port hash_addr (input, 32 bits, byte address, latched at accept).
  - After the final UPDATE, WRITE runs 5 cycles with port_A_we=1, writing byte-swap(H0..H4) to hash_addr+0, +4, +8, +12, +16.
  - done asserts the edge after the last write.
- SHA1_HASH_WRITEBACK_EN undefined:
  - No hash_addr port and no WRITE state.
  - port_A_we and port_A_data_in are tied to 0.

## Test plan
- Empty message: size=0, R=1 -> hash=da39a3ee5e6b4b0d3255bfef95601890afd80709; done on edge E0+98.
- "abc": size=3, for each R in {1,2,4} -> hash=a9993e364706816aba3e25717850c26c9cd0d89d; done on edges E0+98, E0+58 and E0+38 respectively.
- 56-byte "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" -> N=2, hash=84983e441c3bd26ebaae4aa1f95129e5e54670f1.
- Second start asserted mid-hash, then a second start from DONE with "abc" -> first result unaffected by the ignored start; second result a9993e36…9cd0d89d.
- nreset pulsed low during ROUNDS -> all outputs return to reset values immediately; a fresh "abc" run then produces the correct hash.
- With writeback enabled and hash_addr=0x100 on the "abc" run -> writes to 0x100-0x110 with we=1 for exactly 5 cycles; word at 0x100 = 363e99a9.
